// File: rtl/sequence_moore_pkg.sv
// Shared types and constants for the 1011 Moore sequence detector.
package sequence_moore_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,  // idle, no prefix
    S1 = 3'd1,  // seen "1"
    S2 = 3'd2,  // seen "10"
    S3 = 3'd3,  // seen "101"
    S4 = 3'd4   // seen "1011", match
  } state_t;

  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/sequence_moore_if.sv
// Serial bit-stream bundle: the source drives the data bit, the detector drives the match flag.
interface sequence_moore_if;
  logic in;
  logic out;

  modport master (output in, input out);
  modport slave  (input in, output out);
endinterface

// File: rtl/sequence_moore.sv
// Moore detector for the serial pattern 1011 with overlap; out is decoded from the state register only.
module sequence_moore
  import sequence_moore_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  state_t state;
  state_t state_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S0;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S0;
    out        = 1'b0;
    case (state)
      S0: state_next = in ? S1 : S0;
      S1: state_next = in ? S1 : S2;
      S2: state_next = in ? S3 : S0;
      S3: state_next = in ? S4 : S2;
      // Trailing "1" or "10" of the match seeds the next detection.
      S4: begin
        out        = 1'b1;
        state_next = in ? S1 : S2;
      end
      default: state_next = S0;
    endcase
  end

endmodule

// File: tb/tb_sequence_moore.sv
// Directed and random checks of the 1011 Moore detector against hand-computed and shift-register expectations.
module tb_sequence_moore;
  import sequence_moore_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   passed;

  sequence_moore_if bus ();

  sequence_moore dut (
    .clk   (clk),
    .reset (reset),
    .in    (bus.in),
    .out   (bus.out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one bit, let the next rising edge sample it, then settle before sampling out.
  task automatic step(input logic b);
    bus.in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset  = 1'b1;
    bus.in = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    bus.in = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out !== 1'b0)
      $display("FAIL reset_hold: out=%b expected=0", bus.out);
    else passed++;
    // in=1 while reset is held must be ignored
    bus.in = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out !== 1'b0)
      $display("FAIL reset_ignores_in: out=%b expected=0", bus.out);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_overlap();
    logic [10:0] seq;
    logic [10:0] exp;
    seq = 11'b1011011_0111;
    exp = 11'b0001001_0010;
    apply_reset();
    for (int unsigned i = 0; i < 11; i++) begin
      step(seq[10 - i]);
      checks++;
      if (bus.out !== exp[10 - i])
        $display("FAIL overlap bit%0d: out=%b expected=%b", i + 1, bus.out, exp[10 - i]);
      else passed++;
    end
  endtask

  task automatic test_no_false_match();
    logic [8:0] seq;
    seq = 9'b111001010;
    apply_reset();
    for (int unsigned i = 0; i < 9; i++) begin
      step(seq[8 - i]);
      checks++;
      if (bus.out !== 1'b0)
        $display("FAIL no_false bit%0d: out=%b expected=0", i + 1, bus.out);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq;
    logic [7:0] exp;
    seq = 8'b1011_1011;
    exp = 8'b0001_0001;
    apply_reset();
    for (int unsigned i = 0; i < 8; i++) begin
      step(seq[7 - i]);
      checks++;
      if (bus.out !== exp[7 - i])
        $display("FAIL back_to_back bit%0d: out=%b expected=%b", i + 1, bus.out, exp[7 - i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] tail;
    logic [3:0] exp;
    apply_reset();
    step(1'b1);
    step(1'b0);
    step(1'b1);
    apply_reset();
    tail = 4'b1011;
    exp  = 4'b0001;
    for (int unsigned i = 0; i < 4; i++) begin
      step(tail[3 - i]);
      checks++;
      if (bus.out !== exp[3 - i])
        $display("FAIL reset_mid bit%0d: out=%b expected=%b", i + 1, bus.out, exp[3 - i]);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(1'b1);
    step(1'b0);
    step(1'b1);
    step(1'b1);
    checks++;
    if (bus.out !== 1'b1)
      $display("FAIL async_pre: out=%b expected=1", bus.out);
    else passed++;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.out !== 1'b0)
      $display("FAIL async_drop: out=%b expected=0", bus.out);
    else passed++;
    bus.in = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    // Only the released bits count: 0,1,1 alone is not a full pattern.
    step(1'b0);
    step(1'b1);
    step(1'b1);
    checks++;
    if (bus.out !== 1'b0)
      $display("FAIL async_restart: out=%b expected=0", bus.out);
    else passed++;
  endtask

  task automatic test_random();
    logic [3:0] hist;
    logic       b;
    logic       exp;
    int         errs;
    apply_reset();
    hist = '0;
    errs = 0;
    for (int unsigned i = 0; i < 1000; i++) begin
      b = 1'($urandom_range(0, 1));
      step(b);
      hist = {hist[2:0], b};
      exp  = (hist == PATTERN);
      checks++;
      if (bus.out !== exp) begin
        errs++;
        if (errs <= 10)
          $display("FAIL random bit%0d: out=%b expected=%b", i + 1, bus.out, exp);
      end else passed++;
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    reset  = 1'b1;
    bus.in = 1'b0;
    #2;
    test_reset();
    test_overlap();
    test_no_false_match();
    test_back_to_back();
    test_reset_mid();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
